// File: rtl/nios2_ls_irq_pkg.sv
// Shared definitions for the Nios II low-speed interrupt controller:
// register map, irq FSM encoding and ACTIVE register layout.
package nios2_ls_irq_pkg;

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_RAW     = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
    localparam logic [2:0] ADDR_HOLDOFF = 3'd5;
    localparam logic [2:0] ADDR_SWTRIG  = 3'd6;
    localparam logic [2:0] ADDR_RSVD    = 3'd7;

    localparam int ACT_VALID_BIT = 15;
    localparam int ACT_ID_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERTED = 2'd1,
        ST_HOLDOFF  = 2'd2
    } irq_state_e;

    function automatic logic [15:0] pack_active(
        input logic                valid,
        input logic [ACT_ID_W-1:0] id
    );
        logic [15:0] w;
        w = '0;
        w[ACT_VALID_BIT] = valid;
        w[ACT_ID_W-1:0] = id;
        return w;
    endfunction

endpackage

// File: rtl/nios2_ls_irq_prio_enc.sv
// Fixed-priority encoder: lowest-numbered requesting source wins.
// Reports valid=0 and id=0 when no source requests.
module nios2_ls_irq_prio_enc
    import nios2_ls_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0]  req,
    output logic                valid,
    output logic [ACT_ID_W-1:0] id
);

    // Scan high to low so the last hit is the lowest index.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ACT_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/nios2_ls_irq_ctrl.sv
// Avalon-MM interrupt controller: edge/level capture, mask, priority
// report and a single CPU irq with a programmable minimum low gap.
module nios2_ls_irq_ctrl
    import nios2_ls_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 8,
    parameter logic [15:0] HOLDOFF_RST = 16'd0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq
);

    logic               wr_en;
    logic               wr_pend;
    logic               wr_mask;
    logic               wr_mode;
    logic               wr_hold;
    logic               wr_sw;
    logic [NUM_SRC-1:0] wd_src;

    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] irq_in_d;
    logic [NUM_SRC-1:0] set_v;
    logic [NUM_SRC-1:0] clr_v;
    logic [NUM_SRC-1:0] req_v;
    logic [15:0]        holdoff_q;

    logic                act_valid;
    logic [ACT_ID_W-1:0] act_id;
    logic                irq_req;

    irq_state_e  state_q;
    irq_state_e  state_d;
    logic [15:0] holdoff_cnt;
    logic [15:0] cnt_d;
    logic [15:0] rd_mux;

    assign wr_en   = chipselect & ~write_n;
    assign wr_pend = wr_en && (address == ADDR_PENDING);
    assign wr_mask = wr_en && (address == ADDR_MASK);
    assign wr_mode = wr_en && (address == ADDR_MODE);
    assign wr_hold = wr_en && (address == ADDR_HOLDOFF);
    assign wr_sw   = wr_en && (address == ADDR_SWTRIG);
    assign wd_src  = writedata[NUM_SRC-1:0];

    generate
        if (NUM_SRC < 16) begin : g_wd_pad
            logic unused_wd_hi;
            assign unused_wd_hi = ^writedata[15:NUM_SRC];
        end
    endgenerate

    // Edge sources: set beats clear. Level sources: follow the pin.
    assign set_v = (irq_in & ~irq_in_d) | ({NUM_SRC{wr_sw}} & wd_src);
    assign clr_v = {NUM_SRC{wr_pend}} & wd_src;

    assign pending_d = (mode_q & (set_v | (pending_q & ~clr_v)))
                     | (~mode_q & irq_in);

    assign req_v = pending_q & mask_q;

    nios2_ls_irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req   (req_v),
        .valid (act_valid),
        .id    (act_id)
    );

    assign irq_req = act_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            irq_in_d  <= '0;
            holdoff_q <= HOLDOFF_RST;
        end else begin
            pending_q <= pending_d;
            irq_in_d  <= irq_in;
            if (wr_mask) begin
                mask_q <= wd_src;
            end
            if (wr_mode) begin
                mode_q <= wd_src;
            end
            if (wr_hold) begin
                holdoff_q <= writedata;
            end
        end
    end

    // Leaving HOLDOFF goes straight back to ASSERTED when a request
    // is waiting, so irq stays low for exactly the programmed count.
    always_comb begin
        state_d = state_q;
        cnt_d   = holdoff_cnt;
        unique case (state_q)
            ST_IDLE: begin
                if (irq_req) begin
                    state_d = ST_ASSERTED;
                end
            end
            ST_ASSERTED: begin
                if (!irq_req) begin
                    if (holdoff_q == 16'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = holdoff_q;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (holdoff_cnt != 16'd0) begin
                    cnt_d = holdoff_cnt - 16'd1;
                end
                if (holdoff_cnt <= 16'd1) begin
                    state_d = irq_req ? ST_ASSERTED : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            holdoff_cnt <= '0;
        end else begin
            state_q     <= state_d;
            holdoff_cnt <= cnt_d;
        end
    end

    assign irq = (state_q == ST_ASSERTED);

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_PENDING: rd_mux = 16'(pending_q);
            ADDR_MASK:    rd_mux = 16'(mask_q);
            ADDR_MODE:    rd_mux = 16'(mode_q);
            ADDR_RAW:     rd_mux = 16'(irq_in);
            ADDR_ACTIVE:  rd_mux = pack_active(act_valid, act_id);
            ADDR_HOLDOFF: rd_mux = holdoff_q;
            ADDR_SWTRIG:  rd_mux = '0;
            ADDR_RSVD:    rd_mux = '0;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule
